dct_block_ctrl: RTL and testbench

- Sequencer in front of the 8x8 2-D DCT datapath.
- Accepts an 8x8 block of 10-bit samples as 8 row beats over a valid/ready stream and presents the complete block to the DCT core. Holds enable and data until the core reports valid.
- Captures the 64 coefficients and drains them as 8 row beats over a valid/ready output stream.
- Processes one block at a time; handles core timeout with a sticky error flag.

---
 rtl/dct_pkg.sv | 40 ++++
 rtl/dct_row_buf.sv | 50 +++++
 rtl/dct_block_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dct_block_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// ---------------------------------------------------------------------------
// dct_pkg
// Shared definitions for the DCT block sequencer:
//   DCT_W     default sample/coefficient width
//   DCT_ROWS  rows (and columns) per block
//   IDX_W     width of a row index
//   dct_state_e  controller phases: FILL, LAUNCH, WAIT, DRAIN
//   get_sample / get_row  slice helpers for the default-width packing,
//   where element 0 always sits in the most significant field.
// ---------------------------------------------------------------------------
package dct_pkg;

    localparam int DCT_W    = 10;
    localparam int DCT_ROWS = 8;
    localparam int IDX_W    = $clog2(DCT_ROWS);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } dct_state_e;

    // Sample c of a packed row; sample 0 occupies the top W bits.
    function automatic logic [DCT_W-1:0] get_sample(
        input logic [DCT_ROWS*DCT_W-1:0] row,
        input int                        c
    );
        return row[DCT_ROWS*DCT_W-1-DCT_W*c -: DCT_W];
    endfunction

    // Row r of a packed block; row 0 occupies the top 8W bits.
    function automatic logic [DCT_ROWS*DCT_W-1:0] get_row(
        input logic [DCT_ROWS*DCT_ROWS*DCT_W-1:0] blk,
        input int                                 r
    );
        return blk[DCT_ROWS*DCT_ROWS*DCT_W-1-DCT_ROWS*DCT_W*r -: DCT_ROWS*DCT_W];
    endfunction

endpackage

// File: rtl/dct_row_buf.sv
// ---------------------------------------------------------------------------
// dct_row_buf
// Eight-entry register file of 8W-bit rows with every entry visible at once.
// Two ways to write it: one row by index, or all eight rows together from a
// packed 64W-bit block (row 0 in the top bits). A block load wins over an
// indexed write in the same cycle. Contents clear on reset.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en_i      write wr_data_i into entry wr_idx_i
//   wr_idx_i     entry index for the indexed write
//   wr_data_i    row data for the indexed write
//   ld_en_i      load all entries from ld_data_i
//   ld_data_i    packed block for the bulk load
//   rows_o       all entries, rows_o[r] is entry r
// ---------------------------------------------------------------------------
module dct_row_buf
    import dct_pkg::*;
#(
    parameter int W = DCT_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en_i,
    input  logic [IDX_W-1:0]                   wr_idx_i,
    input  logic [DCT_ROWS*W-1:0]              wr_data_i,
    input  logic                               ld_en_i,
    input  logic [DCT_ROWS*DCT_ROWS*W-1:0]     ld_data_i,
    output logic [DCT_ROWS-1:0][DCT_ROWS*W-1:0] rows_o
);

    localparam int ROW_W = DCT_ROWS * W;
    localparam int BLK_W = DCT_ROWS * ROW_W;

    logic [DCT_ROWS-1:0][ROW_W-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (ld_en_i) begin
            for (int r = 0; r < DCT_ROWS; r++) begin
                mem_q[r] <= ld_data_i[BLK_W-1-ROW_W*r -: ROW_W];
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rows_o = mem_q;

endmodule

// File: rtl/dct_block_ctrl.sv
// ---------------------------------------------------------------------------
// dct_block_ctrl
// Sequencer in front of an 8x8 2-D DCT core. Collects a block as eight row
// beats, presents it to the core with dct_enable held until the core answers,
// captures the 64 coefficients and streams them out as eight row beats.
// One block in flight; a core that never answers is abandoned after TIMEOUT
// cycles and flagged with a sticky err_timeout.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready/in_row input row stream (sample 0 in top bits)
//   dct_enable, dct_row0..7  block presented to the core
//   dct_valid, dct_coef      core result, coef(r,c) packed row-major, top first
//   out_valid/out_ready      output row stream
//   out_row, out_last        coefficient row, last-row marker
//   busy                     a block is partially or fully in progress
//   err_timeout              sticky core timeout flag
//   blk_count                fully drained blocks, wrapping
// ---------------------------------------------------------------------------
module dct_block_ctrl
    import dct_pkg::*;
#(
    parameter int W       = DCT_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DCT_ROWS*W-1:0]          in_row,
    output logic                           dct_enable,
    output logic [DCT_ROWS*W-1:0]          dct_row0,
    output logic [DCT_ROWS*W-1:0]          dct_row1,
    output logic [DCT_ROWS*W-1:0]          dct_row2,
    output logic [DCT_ROWS*W-1:0]          dct_row3,
    output logic [DCT_ROWS*W-1:0]          dct_row4,
    output logic [DCT_ROWS*W-1:0]          dct_row5,
    output logic [DCT_ROWS*W-1:0]          dct_row6,
    output logic [DCT_ROWS*W-1:0]          dct_row7,
    input  logic                           dct_valid,
    input  logic [DCT_ROWS*DCT_ROWS*W-1:0] dct_coef,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DCT_ROWS*W-1:0]          out_row,
    output logic                           out_last,
    output logic                           busy,
    output logic                           err_timeout,
    output logic [CNT_W-1:0]               blk_count
);

    localparam int ROW_W = DCT_ROWS * W;
    localparam int TW    = $clog2(TIMEOUT);

    // The counter starts at 0 on the first WAIT cycle and the abort fires on
    // the edge where it would step onto TIMEOUT-1, i.e. TIMEOUT cycles after
    // dct_enable first rose.
    localparam logic [TW-1:0]    T_ABORT  = TW'(TIMEOUT - 2);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(DCT_ROWS - 1);

    dct_state_e       state_q;
    logic [IDX_W-1:0] rcnt_q;
    logic [IDX_W-1:0] ocnt_q;
    logic [TW-1:0]    tcnt_q;
    logic [TW-1:0]    tcnt_d;
    logic             in_ready_q;
    logic             dct_enable_q;
    logic             out_valid_q;
    logic             err_q;
    logic [CNT_W-1:0] blk_q;
    logic [CNT_W-1:0] blk_d;

    logic in_accept;
    logic coef_load;
    logic out_accept;

    logic [DCT_ROWS-1:0][ROW_W-1:0] in_rows;
    logic [DCT_ROWS-1:0][ROW_W-1:0] coef_rows;

    // in_ready_q is only ever set while in FILL, so it alone qualifies a beat.
    assign in_accept  = in_valid && in_ready_q;
    assign coef_load  = (state_q == WAIT) && dct_valid;
    assign out_accept = out_valid_q && out_ready;
    assign tcnt_d     = tcnt_q + TW'(1);
    assign blk_d      = blk_q + CNT_W'(1);

    dct_row_buf #(.W(W)) u_in_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (in_accept),
        .wr_idx_i  (rcnt_q),
        .wr_data_i (in_row),
        .ld_en_i   (1'b0),
        .ld_data_i ('0),
        .rows_o    (in_rows)
    );

    dct_row_buf #(.W(W)) u_coef_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (1'b0),
        .wr_idx_i  ('0),
        .wr_data_i ('0),
        .ld_en_i   (coef_load),
        .ld_data_i (dct_coef),
        .rows_o    (coef_rows)
    );

    // Control FSM. Handshake outputs are registered and updated on the same
    // edge as the state change, so in_ready, dct_enable and out_valid always
    // line up with the phase they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            rcnt_q       <= '0;
            ocnt_q       <= '0;
            tcnt_q       <= '0;
            in_ready_q   <= 1'b0;
            dct_enable_q <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            blk_q        <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (in_accept) begin
                        rcnt_q <= rcnt_q + IDX_W'(1);
                        if (rcnt_q == LAST_ROW) begin
                            state_q      <= LAUNCH;
                            in_ready_q   <= 1'b0;
                            dct_enable_q <= 1'b1;
                        end
                    end
                end

                LAUNCH: begin
                    tcnt_q  <= '0;
                    state_q <= WAIT;
                end

                // A result in the last WAIT cycle still wins over the abort.
                WAIT: begin
                    if (dct_valid) begin
                        dct_enable_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        ocnt_q       <= '0;
                        state_q      <= DRAIN;
                    end else if (tcnt_q == T_ABORT) begin
                        err_q        <= 1'b1;
                        dct_enable_q <= 1'b0;
                        rcnt_q       <= '0;
                        in_ready_q   <= 1'b1;
                        state_q      <= FILL;
                    end else begin
                        tcnt_q <= tcnt_d;
                    end
                end

                DRAIN: begin
                    if (out_accept) begin
                        if (ocnt_q == LAST_ROW) begin
                            blk_q       <= blk_d;
                            out_valid_q <= 1'b0;
                            rcnt_q      <= '0;
                            in_ready_q  <= 1'b1;
                            state_q     <= FILL;
                        end else begin
                            ocnt_q <= ocnt_q + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign dct_enable  = dct_enable_q;
    assign out_valid   = out_valid_q;
    assign err_timeout = err_q;
    assign blk_count   = blk_q;

    // ocnt_q only moves on an accepted beat, so the row is stable under stall.
    assign out_row  = coef_rows[ocnt_q];
    assign out_last = out_valid_q && (ocnt_q == LAST_ROW);
    assign busy     = (state_q != FILL) || (rcnt_q != '0);

    assign dct_row0 = in_rows[0];
    assign dct_row1 = in_rows[1];
    assign dct_row2 = in_rows[2];
    assign dct_row3 = in_rows[3];
    assign dct_row4 = in_rows[4];
    assign dct_row5 = in_rows[5];
    assign dct_row6 = in_rows[6];
    assign dct_row7 = in_rows[7];

endmodule

// File: tb/tb_dct_block_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dct_block_ctrl
// Directed bench for dct_block_ctrl. A table of block records drives fill,
// core response, output back-pressure and the expected block count; a few
// hand-written sequences cover reset values, a spurious core pulse and a
// reset in the middle of a fill.
// ---------------------------------------------------------------------------
module tb_dct_block_ctrl;

    localparam int W  = 10;
    localparam int RW = 8 * W;
    localparam int BW = 64 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [RW-1:0] in_row = '0;
    logic          dct_valid = 1'b0;
    logic [BW-1:0] dct_coef = '0;
    logic          out_ready = 1'b1;

    logic          in_ready;
    logic          dct_enable;
    logic [RW-1:0] dct_row0, dct_row1, dct_row2, dct_row3;
    logic [RW-1:0] dct_row4, dct_row5, dct_row6, dct_row7;
    logic          out_valid;
    logic [RW-1:0] out_row;
    logic          out_last;
    logic          busy;
    logic          err_timeout;
    logic [15:0]   blk_count;

    wire [RW-1:0] dctRows [8];
    assign dctRows[0] = dct_row0;
    assign dctRows[1] = dct_row1;
    assign dctRows[2] = dct_row2;
    assign dctRows[3] = dct_row3;
    assign dctRows[4] = dct_row4;
    assign dctRows[5] = dct_row5;
    assign dctRows[6] = dct_row6;
    assign dctRows[7] = dct_row7;

    dct_block_ctrl #(.W(10), .TIMEOUT(64), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .dct_enable  (dct_enable),
        .dct_row0    (dct_row0),
        .dct_row1    (dct_row1),
        .dct_row2    (dct_row2),
        .dct_row3    (dct_row3),
        .dct_row4    (dct_row4),
        .dct_row5    (dct_row5),
        .dct_row6    (dct_row6),
        .dct_row7    (dct_row7),
        .dct_valid   (dct_valid),
        .dct_coef    (dct_coef),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .err_timeout (err_timeout),
        .blk_count   (blk_count)
    );

    always #5 clk = ~clk;

    int   compared   = 0;
    int   mismatched = 0;
    logic expErr     = 1'b0;

    typedef struct {
        int         base;
        logic [9:0] mask;
        bit         toggle;
        int         coreLat;
        int         stallRow;
        int         stallLen;
        bit         expTimeout;
        int         expBlk;
    } vec_t;

    vec_t vecs [9];

    // Sample c of row r is base+8r+c; the core model returns it XOR mask.
    function automatic logic [RW-1:0] makeRow(input int base, input int r, input logic [9:0] mask);
        logic [RW-1:0] row;
        row = '0;
        for (int c = 0; c < 8; c++) begin
            row[RW-1-W*c -: W] = W'(base + 8 * r + c) ^ mask;
        end
        return row;
    endfunction

    task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [RW-1:0] row);
        in_valid = v;
        in_row   = row;
    endtask

    // Runs one block from the current negedge; returns at the negedge after
    // the last drain beat (or after the timeout abort).
    task automatic runVector(input vec_t v);
        logic [RW-1:0] expOut [8];
        int   r, phase, guard, o, stalls;
        logic accepted, beat, ok;
        for (int i = 0; i < 8; i++) expOut[i] = makeRow(v.base, i, v.mask);

        r = 0; phase = 0; guard = 0;
        while (r < 8 && guard < 200) begin
            if (v.toggle && phase == 1) applyStimulus(1'b0, '0);
            else                        applyStimulus(1'b1, makeRow(v.base, r, 10'h000));
            if (in_valid && r == 7) checkOutput("enable_before_launch", RW'(dct_enable), RW'(0));
            accepted = in_valid && in_ready;
            @(negedge clk);
            if (accepted) r++;
            phase ^= 1;
            guard++;
        end
        applyStimulus(1'b0, '0);
        checkOutput("fill_beats", RW'(r), RW'(8));
        if (r != 8) return;

        checkOutput("enable_at_launch", RW'(dct_enable), RW'(1));
        checkOutput("in_ready_at_launch", RW'(in_ready), RW'(0));
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("dct_row%0d", i), dctRows[i], makeRow(v.base, i, 10'h000));

        ok = 1'b1;
        if (v.expTimeout) begin
            for (int k = 1; k < 64; k++) begin
                @(negedge clk);
                if (dct_enable !== 1'b1 || in_ready !== 1'b0 || err_timeout !== expErr) ok = 1'b0;
            end
            checkOutput("wait_before_timeout", RW'(ok), RW'(1));
            @(negedge clk);
            checkOutput("err_timeout_set", RW'(err_timeout), RW'(1));
            checkOutput("enable_after_abort", RW'(dct_enable), RW'(0));
            checkOutput("in_ready_after_abort", RW'(in_ready), RW'(1));
            checkOutput("busy_after_abort", RW'(busy), RW'(0));
            checkOutput("out_valid_after_abort", RW'(out_valid), RW'(0));
            checkOutput("blk_count_after_abort", RW'(blk_count), RW'(v.expBlk));
            expErr = 1'b1;
            return;
        end

        for (int k = 1; k <= v.coreLat; k++) begin
            @(negedge clk);
            if (dct_enable !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        checkOutput("enable_held_in_wait", RW'(ok), RW'(1));
        dct_valid = 1'b1;
        for (int i = 0; i < 8; i++) dct_coef[BW-1-RW*i -: RW] = expOut[i];
        @(negedge clk);
        dct_valid = 1'b0;
        dct_coef  = '1;
        checkOutput("enable_dropped", RW'(dct_enable), RW'(0));
        checkOutput("first_out_valid", RW'(out_valid), RW'(1));

        o = 0; stalls = 0; guard = 0; ok = 1'b1;
        while (o < 8 && guard < 200) begin
            checkOutput($sformatf("out_row%0d", o), out_row, expOut[o]);
            checkOutput($sformatf("out_valid%0d", o), RW'(out_valid), RW'(1));
            checkOutput($sformatf("out_last%0d", o), RW'(out_last), RW'(o == 7));
            if (in_ready !== 1'b0) ok = 1'b0;
            if (o == v.stallRow && stalls < v.stallLen) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            beat = out_ready && out_valid;
            @(negedge clk);
            if (beat) o++;
            guard++;
        end
        out_ready = 1'b1;
        checkOutput("drain_beats", RW'(o), RW'(8));
        checkOutput("stall_cycles", RW'(stalls), RW'((v.stallRow >= 0) ? v.stallLen : 0));
        checkOutput("in_ready_low_in_drain", RW'(ok), RW'(1));
        checkOutput("out_valid_after_drain", RW'(out_valid), RW'(0));
        checkOutput("in_ready_after_drain", RW'(in_ready), RW'(1));
        checkOutput("busy_after_drain", RW'(busy), RW'(0));
        checkOutput("blk_count", RW'(blk_count), RW'(v.expBlk));
        checkOutput("err_timeout_sticky", RW'(err_timeout), RW'(expErr));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           base  mask    tog lat stallRow stallLen tmo blk
        vecs[0] = '{   0, 10'h000, 0,   6,  -1,      0,      0,  1};
        vecs[1] = '{ 100, 10'h2AA, 1,   3,  -1,      0,      0,  2};
        vecs[2] = '{ 200, 10'h155, 0,   1,   3,      5,      0,  3};
        vecs[3] = '{ 300, 10'h000, 0,   0,  -1,      0,      1,  3};
        vecs[4] = '{ 400, 10'h3FF, 0,  10,  -1,      0,      0,  4};
        vecs[5] = '{ 500, 10'h0F0, 0,   2,  -1,      0,      0,  5};
        vecs[6] = '{ 600, 10'h00F, 0,   2,  -1,      0,      0,  6};
        vecs[7] = '{ 700, 10'h333, 0,   2,  -1,      0,      0,  7};
        vecs[8] = '{  20, 10'h1C7, 0,   4,  -1,      0,      0,  1};

        // Reset values while rst_n is held low.
        #1;
        checkOutput("rst_in_ready", RW'(in_ready), RW'(0));
        checkOutput("rst_dct_enable", RW'(dct_enable), RW'(0));
        checkOutput("rst_out_valid", RW'(out_valid), RW'(0));
        checkOutput("rst_out_row", out_row, RW'(0));
        checkOutput("rst_out_last", RW'(out_last), RW'(0));
        checkOutput("rst_busy", RW'(busy), RW'(0));
        checkOutput("rst_err_timeout", RW'(err_timeout), RW'(0));
        checkOutput("rst_blk_count", RW'(blk_count), RW'(0));
        checkOutput("rst_dct_row0", dct_row0, RW'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_reset", RW'(in_ready), RW'(1));

        for (int i = 0; i < 5; i++) runVector(vecs[i]);

        // A core pulse outside WAIT must not start a drain or touch state.
        dct_valid = 1'b1;
        dct_coef  = '1;
        @(negedge clk);
        dct_valid = 1'b0;
        checkOutput("spurious_out_valid", RW'(out_valid), RW'(0));
        checkOutput("spurious_dct_enable", RW'(dct_enable), RW'(0));
        checkOutput("spurious_in_ready", RW'(in_ready), RW'(1));
        checkOutput("spurious_busy", RW'(busy), RW'(0));
        checkOutput("spurious_blk_count", RW'(blk_count), RW'(4));

        for (int i = 5; i < 8; i++) runVector(vecs[i]);

        // Four stale rows, then an asynchronous reset mid-fill.
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, makeRow(900, r, 10'h000));
            @(negedge clk);
        end
        applyStimulus(1'b0, '0);
        checkOutput("busy_partial_fill", RW'(busy), RW'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("async_in_ready", RW'(in_ready), RW'(0));
        checkOutput("async_busy", RW'(busy), RW'(0));
        checkOutput("async_err_timeout", RW'(err_timeout), RW'(0));
        checkOutput("async_blk_count", RW'(blk_count), RW'(0));
        checkOutput("async_dct_row0", dct_row0, RW'(0));
        checkOutput("async_dct_row3", dct_row3, RW'(0));
        expErr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_midreset", RW'(in_ready), RW'(1));
        runVector(vecs[8]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
